// File: rtl/ni_request_flit_sequencer.sv
// ni_request_flit_sequencer: turns one packet descriptor into HEADER/BODY/TAIL flits
// on the NoC link, using credit-based flow control toward the downstream buffer.
module ni_request_flit_sequencer #(
    parameter int FLIT_WIDTH        = 32,
    parameter int FTYPE_WIDTH       = 2,
    parameter int BASE_WIDTH        = FLIT_WIDTH - FTYPE_WIDTH,
    parameter int COUNTER_WIDTH     = 4,
    parameter int MAX_PAYLOAD_FLITS = 8,
    parameter int CREDITS           = 4,
    parameter int CREDIT_WIDTH      = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [BASE_WIDTH-1:0]    req_header,
    input  logic [COUNTER_WIDTH-1:0] req_payload_flits,
    output logic [COUNTER_WIDTH-1:0] flit_counter,
    output logic                     is_payload,
    input  logic [BASE_WIDTH-1:0]    payload_chunk,
    output logic [FLIT_WIDTH-1:0]    flit_out,
    output logic                     flit_valid,
    input  logic                     credit_in,
    output logic                     busy
);
    localparam logic [FTYPE_WIDTH-1:0] T_HEADER      = FTYPE_WIDTH'(2'b10);
    localparam logic [FTYPE_WIDTH-1:0] T_BODY        = FTYPE_WIDTH'(2'b00);
    localparam logic [FTYPE_WIDTH-1:0] T_TAIL        = FTYPE_WIDTH'(2'b01);
    localparam logic [FTYPE_WIDTH-1:0] T_HEADER_TAIL = FTYPE_WIDTH'(2'b11);
    localparam logic [COUNTER_WIDTH-1:0] MAX_LEN     = COUNTER_WIDTH'(MAX_PAYLOAD_FLITS);
    localparam logic [CREDIT_WIDTH-1:0]  MAX_CREDITS = CREDIT_WIDTH'(CREDITS);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

    state_t                   r_state;
    logic [CREDIT_WIDTH-1:0]  r_credits;
    logic [BASE_WIDTH-1:0]    r_header;
    logic [COUNTER_WIDTH-1:0] r_len;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [FLIT_WIDTH-1:0]    r_flit;
    logic                     r_valid;

    logic                     w_send;
    logic                     w_last;
    logic [COUNTER_WIDTH-1:0] w_len;
    logic [CREDIT_WIDTH-1:0]  w_credits_next;

    // A send uses the registered credit count, so a credit returned at zero only helps next cycle.
    assign w_send = (r_state != S_IDLE) && (r_credits != '0);
    assign w_last = r_cnt == r_len - COUNTER_WIDTH'(1);
    assign w_len  = (req_payload_flits > MAX_LEN) ? MAX_LEN : req_payload_flits;
    assign w_credits_next = (w_send && !credit_in) ? r_credits - CREDIT_WIDTH'(1) :
                            (!w_send && credit_in && r_credits != MAX_CREDITS) ? r_credits + CREDIT_WIDTH'(1) :
                            r_credits;

    assign req_ready    = r_state == S_IDLE;
    assign busy         = r_state != S_IDLE;
    assign is_payload   = r_state == S_PAYLOAD;
    assign flit_counter = r_cnt;
    assign flit_out     = r_flit;
    assign flit_valid   = r_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_credits <= MAX_CREDITS;
            r_header  <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_flit    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            r_valid   <= w_send;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_header <= req_header;
                        r_len    <= w_len;
                        r_state  <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_send) begin
                        r_flit  <= {(r_len == '0) ? T_HEADER_TAIL : T_HEADER, r_header};
                        r_cnt   <= '0;
                        r_state <= (r_len == '0) ? S_IDLE : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_send) begin
                        r_flit  <= {w_last ? T_TAIL : T_BODY, payload_chunk};
                        r_cnt   <= w_last ? '0 : r_cnt + COUNTER_WIDTH'(1);
                        r_state <= w_last ? S_IDLE : S_PAYLOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ni_request_flit_sequencer.sv
// tb_ni_request_flit_sequencer: directed vectors with hand-computed flits, credits and timing.
module tb_ni_request_flit_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [29:0] req_header = '0;
    logic [3:0]  req_payload_flits = '0;
    logic [3:0]  flit_counter;
    logic        is_payload;
    logic [29:0] payload_chunk;
    logic [31:0] flit_out;
    logic        flit_valid;
    logic        credit_in = 1'b0;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    ni_request_flit_sequencer dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_header(req_header), .req_payload_flits(req_payload_flits),
        .flit_counter(flit_counter), .is_payload(is_payload), .payload_chunk(payload_chunk),
        .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [29:0] chunk(input int i);
        return 30'h0ABC000 | 30'(i);
    endfunction

    // Stand-in for the combinational payload shifter.
    assign payload_chunk = is_payload ? chunk(int'(flit_counter)) : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [29:0] hdr, input logic [3:0] len);
        req_valid = 1'b1;
        req_header = hdr;
        req_payload_flits = len;
        step();
        req_valid = 1'b0;
        req_header = 30'h3FFFFFFF;
        req_payload_flits = 4'hF;
        chk("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic exp_flit(input string tag, input logic [1:0] ft, input logic [29:0] data);
        chk({tag, "_valid"}, 32'(flit_valid), 32'd1);
        chk({tag, "_flit"}, flit_out, {ft, data});
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(flit_valid), 32'd0);
        chk("rst_flit", flit_out, 32'd0);
        chk("rst_cnt", 32'(flit_counter), 32'd0);
        chk("rst_isp", 32'(is_payload), 32'd0);
        reset_n = 1'b1;
        step();

        // len=3 with a credit returned every cycle
        credit_in = 1'b1;
        accept(30'h1234567, 4'd3);
        chk("p1_ready_low", 32'(req_ready), 32'd0);
        step();
        chk("p1_hdr_flit", flit_out, 32'h81234567);
        chk("p1_hdr_valid", 32'(flit_valid), 32'd1);
        chk("p1_cnt0", 32'(flit_counter), 32'd0);
        chk("p1_isp", 32'(is_payload), 32'd1);
        step();
        exp_flit("p1_b0", 2'b00, chunk(0));
        chk("p1_cnt1", 32'(flit_counter), 32'd1);
        step();
        exp_flit("p1_b1", 2'b00, chunk(1));
        chk("p1_cnt2", 32'(flit_counter), 32'd2);
        step();
        exp_flit("p1_tail", 2'b01, chunk(2));
        chk("p1_busy_low", 32'(busy), 32'd0);
        chk("p1_isp_low", 32'(is_payload), 32'd0);
        step();
        chk("p1_idle_valid", 32'(flit_valid), 32'd0);
        chk("p1_hold_flit", flit_out, {2'b01, chunk(2)});

        // len=0: single HEADER_TAIL flit
        accept(30'h0055AA1, 4'd0);
        chk("p2_isp", 32'(is_payload), 32'd0);
        step();
        exp_flit("p2_ht", 2'b11, 30'h0055AA1);
        chk("p2_ready", 32'(req_ready), 32'd1);
        chk("p2_isp_after", 32'(is_payload), 32'd0);
        chk("p2_credits", 32'(dut.r_credits), 32'd4);

        // len=6 with no credit returns: stalls after four flits
        credit_in = 1'b0;
        accept(30'h0000F0F, 4'd6);
        step();
        exp_flit("p3_hdr", 2'b10, 30'h0000F0F);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_flit("p3_body", 2'b00, chunk(i));
        end
        step();
        chk("p3_stall_valid", 32'(flit_valid), 32'd0);
        chk("p3_stall_cnt", 32'(flit_counter), 32'd3);
        step();
        chk("p3_stall_valid2", 32'(flit_valid), 32'd0);
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        chk("p3_credit_lat", 32'(flit_valid), 32'd0);
        step();
        exp_flit("p3_b3", 2'b00, chunk(3));
        chk("p3_cnt4", 32'(flit_counter), 32'd4);
        step();
        chk("p3_one_only", 32'(flit_valid), 32'd0);
        credit_in = 1'b1;
        step();
        chk("p3_refill", 32'(flit_valid), 32'd0);
        step();
        exp_flit("p3_b4", 2'b00, chunk(4));
        chk("p3_cred_same", 32'(dut.r_credits), 32'd1);
        step();
        exp_flit("p3_tail", 2'b01, chunk(5));
        chk("p3_cred_same2", 32'(dut.r_credits), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("p3_cred_sat", 32'(dut.r_credits), 32'd4);

        // length 15 clamps to 8
        accept(30'h1000001, 4'd15);
        step();
        exp_flit("p4_hdr", 2'b10, 30'h1000001);
        for (int i = 0; i < 7; i++) begin
            step();
            exp_flit("p4_body", 2'b00, chunk(i));
        end
        chk("p4_cnt7", 32'(flit_counter), 32'd7);
        step();
        exp_flit("p4_tail", 2'b01, chunk(7));
        chk("p4_idle", 32'(busy), 32'd0);

        // async reset mid-payload at flit_counter=2
        accept(30'h0777777, 4'd6);
        step();
        step();
        step();
        chk("p5_cnt2", 32'(flit_counter), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("p5_rst_busy", 32'(busy), 32'd0);
        chk("p5_rst_valid", 32'(flit_valid), 32'd0);
        chk("p5_rst_cnt", 32'(flit_counter), 32'd0);
        chk("p5_rst_cred", 32'(dut.r_credits), 32'd4);
        #2;
        reset_n = 1'b1;
        step();
        accept(30'h2AAAAAA, 4'd1);
        step();
        exp_flit("p5_hdr", 2'b10, 30'h2AAAAAA);
        step();
        exp_flit("p5_tail", 2'b01, chunk(0));
        step();
        chk("p5_done", 32'(flit_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ni_request_flit_sequencer.md
Name: ni_request_flit_sequencer

Overview:
- Request-path packetizer FSM for the NI target/initiator.
- Accepts one packet descriptor per transaction: a pre-built header chunk plus a payload flit count.
- Sequences the combinational payload shifter through flit_counter/is_payload and emits typed flits onto the NoC link.
- Uses credit-based flow control against the downstream switch input buffer.

Parameters:
- FLIT_WIDTH, 32, link flit width.
- FTYPE_WIDTH, 2, flit-type field width (MSBs of flit).
- BASE_WIDTH, FLIT_WIDTH-FTYPE_WIDTH, data part of a flit; matches shifter chunk width.
- COUNTER_WIDTH, 4, width of flit_counter and req_payload_flits.
- MAX_PAYLOAD_FLITS, 8, upper bound on payload flits per packet.
- CREDITS, 4, downstream buffer depth; credit counter reset value.
- CREDIT_WIDTH, 3, credit counter width (must hold CREDITS).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  descriptor valid.
- req_ready  output  1  descriptor accepted when req_valid&&req_ready at a clock edge.
- req_header  input  BASE_WIDTH  header chunk for the packet.
- req_payload_flits  input  COUNTER_WIDTH  number of payload flits, 0..MAX_PAYLOAD_FLITS.
- flit_counter  output  COUNTER_WIDTH  payload flit index to shifter.
- is_payload  output  1  shifter enable.
- payload_chunk  input  BASE_WIDTH  shifter output for the current flit_counter (combinational path).
- flit_out  output  FLIT_WIDTH  {type, data}.
- flit_valid  output  1  flit_out valid this cycle; every valid flit consumes one credit.
- credit_in  input  1  one-cycle pulse returning one credit.
- busy  output  1  high when state != IDLE.

Behaviour:
- Flit types: HEADER=2'b10, BODY=2'b00, TAIL=2'b01, HEADER_TAIL=2'b11.
- Reset (async, reset_n low):
  - State=IDLE; req_ready=1; flit_counter=0; is_payload=0; flit_out=0; flit_valid=0; busy=0.
  - Credit counter=CREDITS; latched header and length cleared.
  - Reset mid-packet abandons the packet; no tail is sent.
- IDLE:
  - req_ready=1.
  - On accept, latch req_header and len=min(req_payload_flits, MAX_PAYLOAD_FLITS), then go to HEADER.
- HEADER:
  - If credits>0: register flit_out={HEADER_TAIL if len==0 else HEADER, header}, flit_valid=1, consume one credit.
  - Then go to IDLE if len==0, else go to PAYLOAD with flit_counter=0.
  - If credits==0: hold state, flit_valid=0.
- PAYLOAD:
  - is_payload=1; flit_counter is registered and is the current index.
  - If credits>0: register flit_out={TAIL if flit_counter==len-1 else BODY, payload_chunk}, flit_valid=1, consume a credit, increment flit_counter.
  - After the last flit: go to IDLE, flit_counter=0, is_payload=0.
  - If credits==0: hold flit_counter, flit_valid=0.
- flit_valid and flit_out are registered; flit_valid is high for exactly one cycle per flit.
- flit_out holds its last value while flit_valid=0.
- Latency:
  - Accept at edge N gives HEADER state in cycle N+1; the header flit is visible after edge N+1 (given credit).
  - Back-to-back payload flits follow at one per cycle with credits available.
  - A new descriptor can be accepted in the IDLE cycle after the tail, so the minimum inter-packet gap is 1 cycle.
- Credits:
  - Send without credit_in: decrement.
  - credit_in without send: increment, saturating at CREDITS (excess pulses ignored).
  - Send and credit_in in the same cycle: unchanged.
  - A credit returned in the cycle credits==0 enables a send on the next cycle, not the same one.
- Descriptor inputs are ignored outside IDLE.

Test Plan:
- Reset, then descriptor header=0x1234567, len=3, credit_in pulsed every cycle -> flits 0x81234567 (HEADER), BODY chunk0, BODY chunk1, TAIL chunk2 on 4 consecutive cycles; flit_counter steps 0,1,2; busy falls after the tail.
- len=0 -> single flit type 2'b11 with the header data; is_payload never asserted; req_ready back the next cycle.
- len=6, no credits returned -> 4 flits sent (header + 3 body), then flit_valid=0 with flit_counter=3 held. One credit_in pulse -> exactly one more BODY flit follows on the next cycle.
- req_payload_flits=15 -> clamped to 8: header + 7 BODY + TAIL at flit_counter=7.
- Simultaneous credit_in and send with credits=1 -> credits stay 1 and streaming continues without a bubble. Extra credit_in pulses with credits=4 -> counter stays 4.
- reset_n asserted during PAYLOAD at flit_counter=2 -> immediate IDLE, flit_valid=0, credits=4. The next descriptor is sent cleanly starting with its HEADER.
